// File: rtl/noc_test_pkg.sv
// Shared types and helpers for the NoC test supervisor and the harnesses it watches.
package noc_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } sup_state_e;

  // Widest harness vector the lowest-set-index helper accepts.
  localparam int MAX_HARNESS = 64;

  // Width of a harness index; a single harness still gets a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the lowest set bit, 0 when no bit is set.
  function automatic int lowest_set_index(input logic [MAX_HARNESS-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_HARNESS - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/noc_watchdog_counter.sv
// Saturating up-counter with a one-shot limit strobe.
// hit is combinational: it flags the increment that takes count from LIMIT-1 to LIMIT.
module noc_watchdog_counter #(
  parameter int CNT_W = 32,
  parameter int LIMIT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  assign hit = inc && (count == LAST);

  // Count up on inc, hold at all-ones, clear has priority over inc.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/noc_test_supervisor.sv
// Simulation supervisor: latches harness successes, watches for errors and a
// global cycle timeout, and reports one registered verdict on done.
// Optional macro NOC_SIM_FINISH_EN (ignored when SYNTHESIS is defined) prints the
// verdict on entry to DONE and ends the simulation ($finish on pass, $fatal on fail).
module noc_test_supervisor
  import noc_test_pkg::*;
#(
  parameter int NUM_HARNESS    = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SETTLE_CYCLES  = 8,
  parameter int CNT_W          = 32,
  parameter int ID_W           = id_width(NUM_HARNESS),
  parameter int SET_W          = $clog2(SETTLE_CYCLES) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_HARNESS-1:0] th_success,
  input  logic [NUM_HARNESS-1:0] th_error,
  output logic                   done,
  output logic                   pass,
  output logic                   fail_error,
  output logic                   fail_timeout,
  output logic [NUM_HARNESS-1:0] success_mask,
  output logic [ID_W-1:0]        first_error_id,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [1:0]             state_dbg,
  output logic [SET_W-1:0]       settle_dbg
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_SETTLE = SETTLE;
  localparam logic [1:0] ST_DONE   = DONE;

  // Handshake: start is a single-cycle request with no ready; it is accepted only
  // in IDLE or DONE and silently dropped in RUN/SETTLE. done is a level that stays
  // high with a frozen verdict until reset or the next accepted start.

  logic [1:0]             state_q, state_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   ferr_q, ferr_d;
  logic                   fto_q, fto_d;
  logic [NUM_HARNESS-1:0] mask_q, mask_d, mask_upd;
  logic [ID_W-1:0]        ferr_id_q, ferr_id_d, err_idx;
  logic                   arm, any_err, mask_full;
  logic                   cyc_inc, cyc_hit;
  logic                   settle_clear, settle_inc, settle_hit;

  assign arm       = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign any_err   = |th_error;
  assign mask_upd  = mask_q | th_success;
  assign mask_full = &mask_upd;
  assign err_idx   = ID_W'(lowest_set_index(MAX_HARNESS'(th_error)));

  assign cyc_inc      = (state_q == ST_RUN) || (state_q == ST_SETTLE);
  assign settle_clear = arm || (state_q == ST_RUN);
  assign settle_inc   = (state_q == ST_SETTLE) && !any_err;

  noc_watchdog_counter #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_cycle_cnt (
    .clock (clock),
    .reset (reset),
    .clear (arm),
    .inc   (cyc_inc),
    .count (cycle_count),
    .hit   (cyc_hit)
  );

  noc_watchdog_counter #(
    .CNT_W (SET_W),
    .LIMIT (SETTLE_CYCLES)
  ) u_settle_cnt (
    .clock (clock),
    .reset (reset),
    .clear (settle_clear),
    .inc   (settle_inc),
    .count (settle_dbg),
    .hit   (settle_hit)
  );

  // Next-state and verdict decision; priority is error > full mask > timeout.
  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    pass_d    = pass_q;
    ferr_d    = ferr_q;
    fto_d     = fto_q;
    mask_d    = mask_q;
    ferr_id_d = ferr_id_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          ferr_d    = 1'b0;
          fto_d     = 1'b0;
          mask_d    = '0;
          ferr_id_d = '0;
        end
      end
      ST_RUN: begin
        mask_d = mask_upd;
        if (any_err) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          ferr_d    = 1'b1;
          ferr_id_d = err_idx;
        end else if (mask_full) begin
          state_d = ST_SETTLE;
        end else if (cyc_hit) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          fto_d   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (any_err) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          ferr_d    = 1'b1;
          ferr_id_d = err_idx;
        end else if (settle_hit) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and verdict registers; reset clears everything.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      ferr_q    <= 1'b0;
      fto_q     <= 1'b0;
      mask_q    <= '0;
      ferr_id_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      ferr_q    <= ferr_d;
      fto_q     <= fto_d;
      mask_q    <= mask_d;
      ferr_id_q <= ferr_id_d;
    end
  end

  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_error     = ferr_q;
  assign fail_timeout   = fto_q;
  assign success_mask   = mask_q;
  assign first_error_id = ferr_id_q;
  assign state_dbg      = state_q;

`ifdef NOC_SIM_FINISH_EN
`ifndef SYNTHESIS
  logic done_seen;

  // Report the verdict once on entry to DONE, then end the run.
  always_ff @(posedge clock) begin
    if (!reset) begin
      done_seen <= 1'b0;
    end else begin
      done_seen <= done_q;
      if (done_q && !done_seen) begin
        $display("noc_test_supervisor: pass=%0b fail_error=%0b fail_timeout=%0b cycle_count=%0d success_mask=%0h first_error_id=%0d",
                 pass_q, ferr_q, fto_q, cycle_count, mask_q, ferr_id_q);
        if (pass_q) $finish;
        else $fatal(1, "noc_test_supervisor: run did not pass");
      end
    end
  end
`endif
`endif

endmodule
